la_capture: RTL and testbench

- Logic-analyzer capture engine. Consumes the LA probe bits that the flip-flop cells drive out: each cell's LA output is its registered output ORed with its LA_Test force.
- Arms on command and triggers on a masked pattern match. Stores DEPTH consecutive samples, then replays them to a host-side reader over a valid/ready handshake.
- Sits between the per-cell LA outputs and the debug/readout path. It is the reading end of the LA probe interface.

---
 rtl/la_pkg.sv | 24 ++
 rtl/la_sample_ram.sv | 27 ++
 rtl/la_capture.sv | 165 ++++++++++++++++
 tb/tb_la_capture.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/la_pkg.sv
// Shared types and helpers for the logic-analyzer capture engine.
package la_pkg;

  // Widest probe vector the trigger helper handles; narrower samples are
  // zero-extended by the caller, so unused upper bits never affect a match.
  localparam int LA_MAX_W = 64;

  // Capture engine states; the encoding is exported on state_o for debug.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    READOUT = 2'd3
  } la_state_t;

  // Masked pattern compare: a bit takes part only where mask is 1, so an
  // all-zero mask matches any sample.
  function automatic logic la_match(input logic [LA_MAX_W-1:0] samp,
                                    input logic [LA_MAX_W-1:0] mask,
                                    input logic [LA_MAX_W-1:0] value);
    return (((samp ^ value) & mask) == '0);
  endfunction

endpackage

// File: rtl/la_sample_ram.sv
// Sample buffer: DEPTH x WIDTH register array with a synchronous write port
// and an asynchronous read port. Contents are deliberately not reset.
module la_sample_ram #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [CNT_W-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [CNT_W-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Store one sample per enabled cycle at the write address.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/la_capture.sv
// Logic-analyzer capture engine: registers the LA probe bits, waits for a
// masked trigger once armed, stores DEPTH consecutive samples starting with
// the triggering one, then replays them over a valid/ready handshake.
module la_capture
  import la_pkg::*;
#(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int CNT_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic [WIDTH-1:0] la_in,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic             busy,
  output logic             done,
  output logic [1:0]       state_o
);

  localparam logic [CNT_W-1:0] LAST_ADDR = CNT_W'(DEPTH - 1);

  la_state_t        state;
  logic [WIDTH-1:0] samp;
  logic [WIDTH-1:0] rd_hold;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic             rd_valid_q;
  logic             busy_q;
  logic             done_q;

  logic             hit;
  logic             xfer;
  logic             mem_we;
  logic [CNT_W-1:0] mem_waddr;
  logic [WIDTH-1:0] mem_rdata;

  // Probe bits pass through one register so trigger and storage see the
  // same, glitch-free sample.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp <= '0;
    end else begin
      samp <= la_in;
    end
  end

  assign hit  = la_match(LA_MAX_W'(samp), LA_MAX_W'(trig_mask), LA_MAX_W'(trig_value));
  assign xfer = rd_valid_q && rd_ready;

  // The hit sample always lands in word 0; every capture cycle after that
  // writes at wr_ptr. An abort suppresses the write since the buffer is
  // being discarded anyway.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_ptr;
    if (!abort) begin
      case (state)
        ARMED: begin
          if (hit) begin
            mem_we    = 1'b1;
            mem_waddr = '0;
          end
        end
        CAPTURE: begin
          mem_we = 1'b1;
        end
        default: begin
          mem_we = 1'b0;
        end
      endcase
    end
  end

  la_sample_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (mem_we),
    .waddr (mem_waddr),
    .wdata (samp),
    .raddr (rd_ptr),
    .rdata (mem_rdata)
  );

  // Control FSM with registered busy/rd_valid/done; abort overrides arm and
  // every other transition, and never produces a done pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      rd_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (xfer) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (abort) begin
        state      <= IDLE;
        rd_valid_q <= 1'b0;
        busy_q     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state  <= ARMED;
              busy_q <= 1'b1;
            end
          end
          ARMED: begin
            if (hit) begin
              wr_ptr <= CNT_W'(1);
              state  <= CAPTURE;
            end
          end
          CAPTURE: begin
            wr_ptr <= wr_ptr + 1'b1;
            if (wr_ptr == LAST_ADDR) begin
              rd_ptr     <= '0;
              rd_valid_q <= 1'b1;
              state      <= READOUT;
            end
          end
          READOUT: begin
            if (xfer && (rd_ptr == LAST_ADDR)) begin
              rd_valid_q <= 1'b0;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              state      <= IDLE;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

  // Remember the last presented word so rd_data stays defined and steady
  // whenever the reader is not being offered data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_hold <= '0;
    end else begin
      rd_hold <= rd_data;
    end
  end

  assign rd_data  = rd_valid_q ? mem_rdata : rd_hold;
  assign rd_valid = rd_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign state_o  = state;

endmodule

// File: tb/tb_la_capture.sv
// Scoreboard bench for la_capture: stimulus pushes the expected readout
// words, a negedge monitor pops and compares on every transfer.
module tb_la_capture;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;

  logic             clk = 1'b0;
  logic             reset;
  logic             arm;
  logic             abort;
  logic [WIDTH-1:0] trig_mask;
  logic [WIDTH-1:0] trig_value;
  logic [WIDTH-1:0] la_in;
  logic [WIDTH-1:0] rd_data;
  logic             rd_valid;
  logic             rd_ready;
  logic             busy;
  logic             done;
  logic [1:0]       state_o;

  int               checks = 0;
  int               errors = 0;
  int               doneCount = 0;
  int               xferCount = 0;
  logic [WIDTH-1:0] expq [$];

  always #5 clk = ~clk;

  la_capture #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .arm        (arm),
    .abort      (abort),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .la_in      (la_in),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .busy       (busy),
    .done       (done),
    .state_o    (state_o)
  );

  // One comparison: counts it and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of control/probe inputs, then advance to the next cycle.
  task automatic applyStimulus(input logic a, input logic ab, input logic [WIDTH-1:0] d);
    arm   = a;
    abort = ab;
    la_in = d;
    step();
  endtask

  task automatic pushRun(input logic [WIDTH-1:0] base);
    for (int i = 0; i < DEPTH; i++) expq.push_back(base + WIDTH'(i));
  endtask

  // Keep the probe counting until done is seen; optional backpressure and
  // up to two stray arm pulses at given cycle offsets.
  task automatic waitDone(input string name, input int budget, input bit bp,
                          input int armA, input int armB);
    int start;
    int c;
    start = doneCount;
    c = 0;
    while (doneCount == start && c < budget) begin
      arm      = (c == armA) || (c == armB);
      abort    = 1'b0;
      la_in    = la_in + 1'b1;
      rd_ready = bp ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1;
      step();
      c++;
    end
    arm = 1'b0;
    rd_ready = 1'b1;
    if (doneCount == start) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=no_done required=done within %0d cycles", name, budget);
    end else begin
      checkOutput({name, "_state_idle"}, 32'(state_o), 32'(S_IDLE));
      checkOutput({name, "_busy"}, 32'(busy), 32'd0);
      step();
      step();
      checkOutput({name, "_done_once"}, 32'(doneCount - start), 32'd1);
      checkOutput({name, "_all_read"}, 32'(expq.size()), 32'd0);
    end
  endtask

  task automatic waitValid(input string name, input int budget);
    int c;
    c = 0;
    while (!rd_valid && c < budget) begin
      arm   = 1'b0;
      abort = 1'b0;
      la_in = la_in + 1'b1;
      step();
      c++;
    end
    if (!rd_valid) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_timeout actual=rd_valid_low required=rd_valid within %0d cycles", name, budget);
    end
  endtask

  // Scoreboard monitor: every accepted word must match the queue head, and a
  // stalled word must equal the head it is still offering.
  always @(negedge clk) begin
    if (!reset) begin
      if (rd_valid) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL rd_unexpected actual=0x%0h required=no_valid", rd_data);
        end else if (rd_ready) begin
          checkOutput("rd_data", 32'(rd_data), 32'(expq[0]));
          void'(expq.pop_front());
          xferCount++;
        end else begin
          checkOutput("rd_hold", 32'(rd_data), 32'(expq[0]));
        end
      end
      if (done) begin
        doneCount++;
        checkOutput("done_after_last", 32'(expq.size()), 32'd0);
        checkOutput("done_rd_valid_low", 32'(rd_valid), 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int d0;
    int x0;
    reset      = 1'b1;
    arm        = 1'b0;
    abort      = 1'b0;
    trig_mask  = '0;
    trig_value = '0;
    la_in      = '0;
    rd_ready   = 1'b0;
    #2;
    checkOutput("reset_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_state", 32'(state_o), 32'(S_IDLE));
    checkOutput("reset_rd_data", 32'(rd_data), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    rd_ready = 1'b1;

    $display("[TB] immediate trigger");
    trig_mask = 8'h00;
    trig_value = 8'h00;
    pushRun(8'h00);
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("imm_state_armed", 32'(state_o), 32'(S_ARMED));
    la_in = 8'h00;
    waitDone("imm", 100, 1'b0, -1, -1);

    $display("[TB] pattern trigger");
    trig_mask = 8'hF0;
    trig_value = 8'hA0;
    pushRun(8'hA5);
    applyStimulus(1'b1, 1'b0, 8'h13);
    applyStimulus(1'b0, 1'b0, 8'h27);
    checkOutput("pat_wait_armed", 32'(state_o), 32'(S_ARMED));
    applyStimulus(1'b0, 1'b0, 8'hA5);
    checkOutput("pat_still_armed", 32'(state_o), 32'(S_ARMED));
    waitDone("pat", 100, 1'b0, -1, -1);

    $display("[TB] backpressure");
    trig_mask = 8'h00;
    pushRun(8'h40);
    applyStimulus(1'b1, 1'b0, 8'h40);
    waitDone("bp", 120, 1'b1, -1, -1);

    $display("[TB] abort during capture");
    d0 = doneCount;
    applyStimulus(1'b1, 1'b0, 8'h60);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 8'h61 + 8'(i));
    checkOutput("abt_cap_in_capture", 32'(state_o), 32'(S_CAPTURE));
    applyStimulus(1'b0, 1'b1, 8'h66);
    abort = 1'b0;
    checkOutput("abt_cap_state", 32'(state_o), 32'(S_IDLE));
    checkOutput("abt_cap_busy", 32'(busy), 32'd0);
    checkOutput("abt_cap_rd_valid", 32'(rd_valid), 32'd0);

    $display("[TB] abort during readout");
    pushRun(8'h70);
    applyStimulus(1'b1, 1'b0, 8'h70);
    la_in = 8'h70;
    waitValid("abt_rd", 40);
    x0 = xferCount;
    step();
    step();
    step();
    rd_ready = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    checkOutput("abt_rd_state", 32'(state_o), 32'(S_IDLE));
    checkOutput("abt_rd_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("abt_rd_xfers", 32'(xferCount - x0), 32'd3);
    expq.delete();
    rd_ready = 1'b1;
    step();
    step();
    checkOutput("abt_no_done", 32'(doneCount - d0), 32'd0);

    $display("[TB] arm with abort, stray arms");
    trig_mask = 8'hFF;
    trig_value = 8'h55;
    applyStimulus(1'b1, 1'b0, 8'h00);
    checkOutput("armab_armed", 32'(state_o), 32'(S_ARMED));
    applyStimulus(1'b1, 1'b1, 8'h00);
    checkOutput("armab_idle", 32'(state_o), 32'(S_IDLE));
    checkOutput("armab_busy", 32'(busy), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00);
    trig_mask = 8'h00;
    pushRun(8'h80);
    applyStimulus(1'b1, 1'b0, 8'h80);
    la_in = 8'h80;
    waitDone("stray", 100, 1'b0, 5, 20);

    $display("[TB] async reset in readout");
    d0 = doneCount;
    pushRun(8'h90);
    applyStimulus(1'b1, 1'b0, 8'h90);
    la_in = 8'h90;
    waitValid("rst", 40);
    step();
    #1;
    reset = 1'b1;
    #2;
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_state", 32'(state_o), 32'(S_IDLE));
    reset = 1'b0;
    expq.delete();
    step();
    step();
    checkOutput("rst_no_done", 32'(doneCount - d0), 32'd0);
    pushRun(8'hC0);
    applyStimulus(1'b1, 1'b0, 8'hC0);
    la_in = 8'hC0;
    waitDone("post_rst", 100, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
